tc_timer: RTL

Memory-mapped timer/counter device on the system bridge, one instance per timer window (TC0 at 0x7F00–0x7F0B, TC1 at 0x7F10–0x7F1B). The bridge routes decoded CPU M-stage word loads and stores here. The block's irq output drives one bit of the CPU's HWInt[5:0] to CP0. It counts down from a programmed preset and raises an interrupt in one-shot or auto-reload mode.

---
 rtl/tc_timer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/tc_timer.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a masked level irq.
// Optional: define TC_PRESCALE_EN to divide the count rate by PRESCALE.
module tc_timer #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CNT, ST_INT} state_t;

  localparam logic [1:0] MODE_RELOAD = 2'd1;

  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("tc_timer: PRESCALE out of range");
  end

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_ctrl, w_ctrl_nxt;
  logic [31:0] r_preset, w_preset_nxt;
  logic [31:0] r_count, w_count_nxt;
  logic        r_flag, w_flag_nxt;
  logic        w_step;
  logic        w_unused_addr;

  assign w_unused_addr = ^{addr[31:4], addr[1:0]};

`ifdef TC_PRESCALE_EN
  localparam logic [15:0] PSC_LAST = 16'(PRESCALE - 1);
  logic [15:0] r_psc;

  assign w_step = (r_psc == PSC_LAST);

  // Prescaler only advances while counting; any other state restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 r_psc <= '0;
    else if (r_state != ST_CNT) r_psc <= '0;
    else if (w_step)            r_psc <= '0;
    else                        r_psc <= r_psc + 16'd1;
  end
`else
  assign w_step = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_ctrl   <= '0;
      r_preset <= '0;
      r_count  <= '0;
      r_flag   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ctrl   <= w_ctrl_nxt;
      r_preset <= w_preset_nxt;
      r_count  <= w_count_nxt;
      r_flag   <= w_flag_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ctrl_nxt   = r_ctrl;
    w_preset_nxt = r_preset;
    w_count_nxt  = r_count;
    w_flag_nxt   = r_flag;
    case (r_state)
      ST_IDLE: if (r_ctrl[0]) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!r_ctrl[0]) begin
          w_state_nxt = ST_IDLE;
        end else if (w_step) begin
          if (r_count > 32'd1) begin
            w_count_nxt = r_count - 32'd1;
          end else begin
            w_count_nxt = '0;
            w_flag_nxt  = 1'b1;
            w_state_nxt = ST_INT;
          end
        end
      end
      ST_INT: begin
        if (r_ctrl[2:1] == MODE_RELOAD) begin
          w_state_nxt = ST_LOAD;
          w_flag_nxt  = 1'b0;
        end else begin
          w_state_nxt   = ST_IDLE;
          w_ctrl_nxt[0] = 1'b0;
        end
      end
    endcase
    // CPU writes are applied last so they override same-cycle FSM updates.
    if (we) begin
      case (addr[3:2])
        2'd0: begin
          w_ctrl_nxt = wdata[3:0];
          w_flag_nxt = 1'b0;
        end
        2'd1: begin
          w_preset_nxt = wdata;
          w_flag_nxt   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (addr[3:2])
      2'd0:    rdata = {28'd0, r_ctrl};
      2'd1:    rdata = r_preset;
      2'd2:    rdata = r_count;
      default: rdata = '0;
    endcase
  end

  assign irq = r_flag & r_ctrl[3];

endmodule
